// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req searching upward from last_owner+1, wrapping.
// Purely combinational; no state, no backpressure.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_owner) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, bounded bursts.
// Latency: req seen in IDLE at cycle t -> first write at t+1; one IDLE cycle between bursts.
// Backpressure: fifo_full drops gnt and freezes the burst; FIFO_ARB_PRIO0_EN gives producer 0 priority.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_ena,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [IDX_W-1:0]          fifo_wr_src,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] rr_winner, pick;
    logic             any_req, active, owner_req, xfer, bounded;
    logic [DATA_W-1:0] owner_dat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (rr_winner),
        .any_req    (any_req)
    );

`ifdef FIFO_ARB_PRIO0_EN
    assign pick    = req[0] ? '0 : rr_winner;
    assign bounded = (owner_q != '0);
`else
    assign pick    = rr_winner;
    assign bounded = 1'b1;
`endif

    // Reset is sampled at the edge, but gating here drops an in-flight grant in the reset cycle itself.
    assign active    = (state_q == BURST) && rst_n;
    assign owner_req = req[owner_q];
    assign xfer      = active && owner_req && !fifo_full;

    always_comb begin
        owner_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_dat = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (active && !fifo_full) begin
            gnt[owner_q] = 1'b1;
        end
    end

    assign fifo_wr_ena  = xfer;
    assign fifo_wr_data = active ? owner_dat : '0;
    assign fifo_wr_src  = active ? owner_q : '0;
    assign busy         = active;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (!owner_req || (xfer && bounded && (beat_cnt_q == LAST_BEAT))) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            last_owner_q <= LAST_IDX;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios push expected writes, a negedge monitor checks them.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr_ena;
    logic [3:0]  fifo_wr_data;
    logic [1:0]  fifo_wr_src;
    logic        busy;

    fifo_wr_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_ena  (fifo_wr_ena),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_src  (fifo_wr_src),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [1:0] src;
        logic [3:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] dat_of(input int i);
        logic [15:0] d;
        d = req_data;
        return d[i*4 +: 4];
    endfunction

    task automatic push(input int t, input int s);
        exp_t e;
        e.t   = t;
        e.src = 2'(s);
        e.dat = dat_of(s);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Monitor: every write strobe must match the head of the expected queue, including its cycle.
    always @(negedge clk) begin
        if (fifo_wr_ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: src %0d data %0h at cycle %0d, none expected", fifo_wr_src, fifo_wr_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_cycle", 32'(cyc), 32'(e.t));
                chk("wr_src", 32'(fifo_wr_src), 32'(e.src));
                chk("wr_data", 32'(fifo_wr_data), 32'(e.dat));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        req_data  = 16'h4A21;
        fifo_full = 1'b0;
        repeat (3) step();
        at_neg();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wr_ena", 32'(fifo_wr_ena), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_src", 32'(fifo_wr_src), 32'h0);
        chk("rst_data", 32'(fifo_wr_data), 32'h0);
        step();
        rst_n = 1'b1;

        // Single requester, 3 beats then drop.
        step();
        c = cyc;
        req = 4'b0100;
        for (int j = 1; j <= 3; j++) push(c + j, 2);
        at_neg();
        chk("s1_idle_busy", 32'(busy), 32'h0);
        chk("s1_idle_gnt", 32'(gnt), 32'h0);
        step();
        at_neg();
        chk("s1_burst_busy", 32'(busy), 32'h1);
        chk("s1_burst_gnt", 32'(gnt), 32'h4);
        step();
        step();
        step();
        req = 4'b0000;
        at_neg();
        chk("s1_drop_busy", 32'(busy), 32'h1);
        step();
        at_neg();
        chk("s1_rel_busy", 32'(busy), 32'h0);
        chk("s1_rel_src", 32'(fifo_wr_src), 32'h0);
        chk("s1_rel_data", 32'(fifo_wr_data), 32'h0);

        // Fresh reset, then all four requesting: 0,1,2,3,0 bursts of 4 with an idle gap.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        c = cyc;
        req = 4'b1111;
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 4; j++) push(c + 1 + 5*k + j, k % 4);
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 5) begin
                at_neg();
                chk("s2_gap_busy", 32'(busy), 32'h0);
            end
        end
        req = 4'b0000;

        // Owner 1 writes 2 beats, FIFO full for 5 cycles, then exactly 2 more beats.
        step();
        c = cyc;
        req = 4'b0010;
        push(c + 1, 1);
        push(c + 2, 1);
        push(c + 8, 1);
        push(c + 9, 1);
        step();
        step();
        step();
        fifo_full = 1'b1;
        at_neg();
        chk("s3_full_gnt", 32'(gnt), 32'h0);
        chk("s3_full_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 4; k++) step();
        at_neg();
        chk("s3_full_gnt_late", 32'(gnt), 32'h0);
        step();
        fifo_full = 1'b0;
        at_neg();
        chk("s3_resume_gnt", 32'(gnt), 32'h2);
        step();
        step();
        req = 4'b0000;
        at_neg();
        chk("s3_rel_busy", 32'(busy), 32'h0);

        // Owner 3 sends one beat then drops; producer 0 wins next.
        step();
        c = cyc;
        req = 4'b1001;
        push(c + 1, 3);
        for (int j = 4; j <= 7; j++) push(c + j, 0);
        step();
        step();
        req = 4'b0001;
        at_neg();
        chk("s4_drop_busy", 32'(busy), 32'h1);
        chk("s4_drop_gnt", 32'(gnt), 32'h8);
        step();
        at_neg();
        chk("s4_rel_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 5; k++) step();
        req = 4'b0000;

        // Reset during a burst with two beats done; producer 0 wins afterwards.
        step();
        c = cyc;
        req = 4'b0100;
        push(c + 1, 2);
        push(c + 2, 2);
        step();
        step();
        step();
        rst_n = 1'b0;
        at_neg();
        chk("s5_rst_gnt", 32'(gnt), 32'h0);
        chk("s5_rst_wr_ena", 32'(fifo_wr_ena), 32'h0);
        chk("s5_rst_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        req = 4'b1111;
        for (int j = 5; j <= 8; j++) push(c + j, 0);
        for (int k = 0; k < 5; k++) step();
        req = 4'b0000;
        at_neg();
        chk("s5_rel_busy", 32'(busy), 32'h0);

        repeat (3) step();
        at_neg();
        chk("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port among NUM_REQ producers.
- Grants one producer at a time for a bounded burst and forwards its data beats to the FIFO.
- Stalls on FIFO full and records which producer wrote each beat.
- Sits between the producer blocks and the FIFO's wr_ena/wr_data/full pins.

Parameters:
- NUM_REQ, 4, number of producers.
- IDX_W, 2, width of the producer index; clog2(NUM_REQ).
- DATA_W, 4, beat width; matches the FIFO data width.
- MAX_BURST, 4, maximum beats per grant; must be >= 1.
- CNT_W, 2, width of the beat counter; clog2(MAX_BURST), minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-producer valid; a producer holds it while it has beats to send.
- req_data  in  NUM_REQ*DATA_W  producer data; producer i drives slice [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  per-producer ready; a beat transfers when req[i] && gnt[i].
- fifo_full  in  1  full flag from the FIFO.
- fifo_wr_ena  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_W  FIFO write data.
- fifo_wr_src  out  IDX_W  index of the producer that owns the current beat.
- busy  out  1  high while in BURST.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
- Reset values:
  - state=IDLE, owner=0, beat_cnt=0, last_owner=NUM_REQ-1, so producer 0 wins first.
  - Outputs at reset: gnt=0, fifo_wr_ena=0, busy=0.
  - fifo_wr_src=0 and fifo_wr_data=0 while not in BURST.
- Reset mid-burst: the in-flight grant is dropped in the same cycle; no write is issued in that cycle.
- State IDLE:
  - gnt=0.
  - If any req bit is set, owner <= first set req index searching upward from last_owner+1, wrapping modulo NUM_REQ.
  - Also beat_cnt <= 0 and state <= BURST.
- State BURST:
  - gnt[owner] = !fifo_full; all other gnt bits are 0. Combinational from registered state and fifo_full.
  - xfer = req[owner] && !fifo_full.
  - fifo_wr_ena = xfer; fifo_wr_data = req_data slice of owner; fifo_wr_src = owner.
  - On xfer, beat_cnt increments.
  - Release to IDLE and set last_owner <= owner when either:
    - xfer occurs with beat_cnt == MAX_BURST-1, or
    - req[owner] == 0 (no write that cycle).
- Latency: req seen in IDLE at cycle t gives first possible grant and write at cycle t+1. There is one IDLE cycle between bursts.
- FIFO full:
  - Holds the burst: no gnt, no write, beat_cnt frozen, state stays BURST, owner kept.
  - Arbitration never drops a producer because of full.
- Simultaneous events:
  - fifo_full and req[owner] deassert in the same cycle: release, no write.
  - New requests from other producers during BURST are ignored until the next IDLE.
- Fairness: with all producers requesting continuously, grants rotate 0,1,2,3,0,...; each burst is MAX_BURST beats when the FIFO is not full.
- Producer contract: a producer does not change req_data while req is high and its gnt is low.

Optional Feature:
- Macro: FIFO_ARB_PRIO0_EN.
- Defined:
  - In IDLE, req[0] set always wins regardless of last_owner.
  - Producer 0 bursts are unbounded: release only when req[0] drops.
- Undefined: pure round-robin as above; no priority logic synthesized.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE=1'b0, BURST=1'b1);
  - default constants NUM_REQ, DATA_W, MAX_BURST.
- One sub-module, rr_pick: a combinational rotate-priority encoder.
  - Inputs: req, last_owner.
  - Outputs: winner index, any_req.
  - Instantiated once.

Test Plan:
- Reset then single requester: req=4'b0100, req_data slice 2 = 4'hA held for 3 beats, then dropped.
  - Required: IDLE 1 cycle, then fifo_wr_ena for 3 cycles with fifo_wr_src=2 and data 4'hA.
  - Then release to IDLE and busy=0.
- All four requesting continuously, fifo_full=0, MAX_BURST=4:
  - Required: write sources 0×4, 1×4, 2×4, 3×4, 0×4, with one idle cycle between bursts.
- FIFO full mid-burst: owner 1 writes 2 beats, fifo_full=1 for 5 cycles, then 0.
  - Required: gnt=0 and no writes during full, beat_cnt held.
  - Required: exactly 2 further beats from owner 1, then release.
- Requester drops early: owner 3 sends 1 beat, then req[3]=0.
  - Required: release next cycle, last_owner=3, next winner is 0 if requesting.
- rst_n=0 during BURST with beat_cnt=2:
  - Required: same cycle fifo_wr_ena=0 and all gnt=0.
  - Required: after release, producer 0 wins first even if others request.
- FIFO_ARB_PRIO0_EN defined, req=4'b1111 after owner 0 finishes:
  - Required: owner 0 re-granted immediately and holds for 6 beats while req[0] stays high.
